// File: rtl/word_frame_sequencer.sv
// word_frame_sequencer
// Takes one clipped-word descriptor and splits the word's range in the circular
// sample buffer into overlapping analysis frames. Frames go to the feature
// extractor one at a time, and each frame must complete before the next one is
// issued. All outputs are registered.
module word_frame_sequencer #(
  parameter int BUF_DEPTH  = 1024,
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128,
  parameter int MIN_LEN    = 64,
  parameter int MAX_FRAMES = 16
) (
  input  logic        iclk,
  input  logic        irstn,
  input  logic        irts,
  output logic        ortr,
  input  logic [31:0] istart_addr,
  input  logic [31:0] iend_addr,
  output logic        oframe_rts,
  input  logic        iframe_rtr,
  output logic [31:0] oframe_addr,
  output logic [15:0] oframe_len,
  output logic        oframe_last,
  input  logic        iframe_done,
  output logic        oword_done,
  output logic        oerr,
  output logic [7:0]  oframe_count,
  output logic        obusy
);

  localparam logic [31:0] ADDR_MASK   = 32'(BUF_DEPTH - 1);
  localparam logic [31:0] FRAME_LEN_W = 32'(FRAME_LEN);
  localparam logic [31:0] HOP_W       = 32'(HOP);
  localparam logic [31:0] MIN_LEN_W   = 32'(MIN_LEN);
  localparam logic [7:0]  LAST_K      = 8'(MAX_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic        ortr_r, ortr_nx_s;
  logic        rts_r, rts_nx_s;
  logic [31:0] addr_r, addr_nx_s;
  logic [15:0] len_r, len_nx_s;
  logic        last_r, last_nx_s;
  logic        word_done_r, word_done_nx_s;
  logic        err_r, err_nx_s;
  logic [7:0]  count_r, count_nx_s;
  logic        busy_r, busy_nx_s;
  logic [31:0] rem_r, rem_nx_s;   // samples remaining from the current frame start
  logic [7:0]  k_r, k_nx_s;       // index of the current frame within the word

  logic        accept_s;
  logic        short_s;
  logic [31:0] word_len_s;
  logic [31:0] adv_rem_s;
  logic [31:0] adv_addr_s;
  logic [7:0]  adv_k_s;

  // A frame is FRAME_LEN samples long unless the word ends sooner.
  function automatic logic [15:0] frame_len_f(input logic [31:0] rem);
    frame_len_f = (rem < FRAME_LEN_W) ? rem[15:0] : FRAME_LEN_W[15:0];
  endfunction

  // A frame is the last one if it reaches the end of the word or the frame cap.
  function automatic logic frame_last_f(input logic [31:0] rem, input logic [7:0] k);
    frame_last_f = (rem <= FRAME_LEN_W) || (k == LAST_K);
  endfunction

  // Word length wraps modulo the buffer depth, so end < start is a legal word.
  assign word_len_s = ((iend_addr - istart_addr) & ADDR_MASK) + 32'd1;
  assign short_s    = (word_len_s < MIN_LEN_W);
  assign accept_s   = (state_r == IDLE) && irts && ortr_r;
  assign adv_rem_s  = rem_r - HOP_W;
  assign adv_addr_s = (addr_r + HOP_W) & ADDR_MASK;
  assign adv_k_s    = k_r + 8'd1;

  assign ortr         = ortr_r;
  assign oframe_rts   = rts_r;
  assign oframe_addr  = addr_r;
  assign oframe_len   = len_r;
  assign oframe_last  = last_r;
  assign oword_done   = word_done_r;
  assign oerr         = err_r;
  assign oframe_count = count_r;
  assign obusy        = busy_r;

  // State register.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: accept, issue, wait for completion, finish.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:      state_nx_s = (accept_s && !short_s) ? ISSUE : IDLE;
      ISSUE:     state_nx_s = iframe_rtr ? WAIT_DONE : ISSUE;
      WAIT_DONE: begin
        if (iframe_done) begin
          state_nx_s = last_r ? DONE : ISSUE;
        end else begin
          state_nx_s = WAIT_DONE;
        end
      end
      DONE:      state_nx_s = IDLE;
      default:   state_nx_s = IDLE;
    endcase
  end

  // Next values of the output and payload registers; the payload advances
  // incrementally by HOP after each completed non-final frame.
  always_comb begin
    ortr_nx_s      = (state_nx_s == IDLE);
    rts_nx_s       = (state_nx_s == ISSUE);
    busy_nx_s      = (state_nx_s != IDLE);
    word_done_nx_s = (state_nx_s == DONE);
    err_nx_s       = 1'b0;
    addr_nx_s      = addr_r;
    len_nx_s       = len_r;
    last_nx_s      = last_r;
    count_nx_s     = count_r;
    rem_nx_s       = rem_r;
    k_nx_s         = k_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          count_nx_s = 8'd0;
          k_nx_s     = 8'd0;
          if (short_s) begin
            err_nx_s = 1'b1;
          end else begin
            addr_nx_s = istart_addr & ADDR_MASK;
            rem_nx_s  = word_len_s;
            len_nx_s  = frame_len_f(word_len_s);
            last_nx_s = frame_last_f(word_len_s, 8'd0);
          end
        end else begin
          err_nx_s = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (iframe_done) begin
          count_nx_s = count_r + 8'd1;
          if (!last_r) begin
            addr_nx_s = adv_addr_s;
            rem_nx_s  = adv_rem_s;
            k_nx_s    = adv_k_s;
            len_nx_s  = frame_len_f(adv_rem_s);
            last_nx_s = frame_last_f(adv_rem_s, adv_k_s);
          end else begin
            k_nx_s = k_r;
          end
        end else begin
          count_nx_s = count_r;
        end
      end
      default: begin
        count_nx_s = count_r;
      end
    endcase
  end

  // Output and payload registers.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      ortr_r      <= 1'b0;
      rts_r       <= 1'b0;
      addr_r      <= 32'd0;
      len_r       <= 16'd0;
      last_r      <= 1'b0;
      word_done_r <= 1'b0;
      err_r       <= 1'b0;
      count_r     <= 8'd0;
      busy_r      <= 1'b0;
      rem_r       <= 32'd0;
      k_r         <= 8'd0;
    end else begin
      ortr_r      <= ortr_nx_s;
      rts_r       <= rts_nx_s;
      addr_r      <= addr_nx_s;
      len_r       <= len_nx_s;
      last_r      <= last_nx_s;
      word_done_r <= word_done_nx_s;
      err_r       <= err_nx_s;
      count_r     <= count_nx_s;
      busy_r      <= busy_nx_s;
      rem_r       <= rem_nx_s;
      k_r         <= k_nx_s;
    end
  end

endmodule

// File: tb/tb_word_frame_sequencer.sv
// Testbench for word_frame_sequencer: directed words plus randomized words,
// checked against a frame-list model built from the framing arithmetic.
module tb_word_frame_sequencer;

  localparam int BUF_DEPTH  = 1024;
  localparam int FRAME_LEN  = 256;
  localparam int HOP        = 128;
  localparam int MIN_LEN    = 64;
  localparam int MAX_FRAMES = 4;

  logic        iclk = 1'b0;
  logic        irstn = 1'b0;
  logic        irts = 1'b0;
  logic        ortr;
  logic [31:0] istart_addr = 32'd0;
  logic [31:0] iend_addr = 32'd0;
  logic        oframe_rts;
  logic        iframe_rtr = 1'b0;
  logic [31:0] oframe_addr;
  logic [15:0] oframe_len;
  logic        oframe_last;
  logic        iframe_done = 1'b0;
  logic        oword_done;
  logic        oerr;
  logic [7:0]  oframe_count;
  logic        obusy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        last;
  } frame_t;

  frame_t exp_q[$];

  word_frame_sequencer #(
    .BUF_DEPTH(BUF_DEPTH), .FRAME_LEN(FRAME_LEN), .HOP(HOP),
    .MIN_LEN(MIN_LEN), .MAX_FRAMES(MAX_FRAMES)
  ) dut (
    .iclk(iclk), .irstn(irstn), .irts(irts), .ortr(ortr),
    .istart_addr(istart_addr), .iend_addr(iend_addr),
    .oframe_rts(oframe_rts), .iframe_rtr(iframe_rtr),
    .oframe_addr(oframe_addr), .oframe_len(oframe_len), .oframe_last(oframe_last),
    .iframe_done(iframe_done), .oword_done(oword_done), .oerr(oerr),
    .oframe_count(oframe_count), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  // Expected frame list for a word, straight from the framing arithmetic.
  task automatic build_model(input logic [31:0] s, input logic [31:0] e);
    int     wl;
    int     rem;
    frame_t f;
    exp_q.delete();
    wl = int'((e - s) % 32'(BUF_DEPTH)) + 1;
    if (wl < MIN_LEN) return;
    for (int k = 0; k < MAX_FRAMES; k++) begin
      rem    = wl - k * HOP;
      f.addr = (s + 32'(k * HOP)) % 32'(BUF_DEPTH);
      f.len  = 16'((rem < FRAME_LEN) ? rem : FRAME_LEN);
      f.last = (rem <= FRAME_LEN) || (k == MAX_FRAMES - 1);
      exp_q.push_back(f);
      if (f.last) break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ortr"}, 32'(ortr), 32'd0);
    chk({tag, "_rts"}, 32'(oframe_rts), 32'd0);
    chk({tag, "_addr"}, oframe_addr, 32'd0);
    chk({tag, "_len"}, 32'(oframe_len), 32'd0);
    chk({tag, "_last"}, 32'(oframe_last), 32'd0);
    chk({tag, "_wdone"}, 32'(oword_done), 32'd0);
    chk({tag, "_err"}, 32'(oerr), 32'd0);
    chk({tag, "_count"}, 32'(oframe_count), 32'd0);
    chk({tag, "_busy"}, 32'(obusy), 32'd0);
  endtask

  // Asynchronous reset in the middle of a word, then release.
  task automatic do_reset();
    @(negedge iclk);
    #2 irstn = 1'b0;
    #1 chk_all_zero("midreset");
    iframe_done = 1'b1;
    @(negedge iclk);
    iframe_done = 1'b0;
    @(negedge iclk);
    chk("midreset_no_wdone", 32'(oword_done), 32'd0);
    irstn = 1'b1;
    #1 chk("release_ortr_low", 32'(ortr), 32'd0);
    @(negedge iclk);
    chk("release_ortr_high", 32'(ortr), 32'd1);
    chk("release_busy", 32'(obusy), 32'd0);
  endtask

  // Present one descriptor and service its frames; abort_k >= 0 resets the
  // DUT while waiting for completion of that frame.
  task automatic run_word(input logic [31:0] s, input logic [31:0] e,
                          input int bp_lo, input int bp_hi,
                          input int d_lo, input int d_hi, input int abort_k);
    frame_t f;
    int     cnt;
    int     nbp;
    int     nd;
    bit     got;
    build_model(s, e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ortr === 1'b1) got = 1'b1;
      else step();
    end
    chk("ortr_ready", 32'(ortr), 32'd1);
    irts = 1'b1;
    istart_addr = s;
    iend_addr = e;
    step();
    irts = 1'b0;
    istart_addr = $urandom;
    iend_addr = $urandom;
    if (exp_q.size() == 0) begin
      chk("reject_err", 32'(oerr), 32'd1);
      chk("reject_no_rts", 32'(oframe_rts), 32'd0);
      chk("reject_ortr", 32'(ortr), 32'd1);
      chk("reject_count", 32'(oframe_count), 32'd0);
      return;
    end
    chk("accept_ortr_low", 32'(ortr), 32'd0);
    chk("accept_err_quiet", 32'(oerr), 32'd0);
    cnt = 0;
    foreach (exp_q[k]) begin
      f = exp_q[k];
      chk("frame_rts", 32'(oframe_rts), 32'd1);
      chk("frame_addr", oframe_addr, f.addr);
      chk("frame_len", 32'(oframe_len), 32'(f.len));
      chk("frame_last", 32'(oframe_last), 32'(f.last));
      chk("frame_busy", 32'(obusy), 32'd1);
      chk("frame_count", 32'(oframe_count), 32'(cnt));
      nbp = $urandom_range(bp_hi, bp_lo);
      for (int i = 0; i < nbp; i++) begin
        iframe_done = 1'($urandom_range(1, 0));
        step();
        iframe_done = 1'b0;
        chk("bp_rts", 32'(oframe_rts), 32'd1);
        chk("bp_addr", oframe_addr, f.addr);
        chk("bp_len", 32'(oframe_len), 32'(f.len));
        chk("bp_last", 32'(oframe_last), 32'(f.last));
        chk("bp_count", 32'(oframe_count), 32'(cnt));
        chk("bp_ortr", 32'(ortr), 32'd0);
      end
      iframe_rtr = 1'b1;
      iframe_done = 1'($urandom_range(1, 0));
      step();
      iframe_rtr = 1'b0;
      iframe_done = 1'b0;
      chk("xfer_rts_low", 32'(oframe_rts), 32'd0);
      chk("xfer_count", 32'(oframe_count), 32'(cnt));
      if (k == abort_k) begin
        do_reset();
        return;
      end
      nd = $urandom_range(d_hi, d_lo);
      for (int i = 0; i < nd; i++) begin
        irts = 1'($urandom_range(1, 0));
        step();
        chk("wait_count", 32'(oframe_count), 32'(cnt));
        chk("wait_rts", 32'(oframe_rts), 32'd0);
        chk("wait_ortr", 32'(ortr), 32'd0);
      end
      irts = 1'b0;
      iframe_done = 1'b1;
      step();
      iframe_done = 1'b0;
      cnt++;
      chk("done_count", 32'(oframe_count), 32'(cnt));
      if (f.last) begin
        chk("word_done", 32'(oword_done), 32'd1);
        chk("word_done_rts", 32'(oframe_rts), 32'd0);
        step();
        chk("word_done_pulse", 32'(oword_done), 32'd0);
        chk("idle_ortr", 32'(ortr), 32'd1);
        chk("idle_busy", 32'(obusy), 32'd0);
        chk("count_hold", 32'(oframe_count), 32'(cnt));
      end else begin
        chk("not_word_done", 32'(oword_done), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] s;
    int          wl;
    irstn = 1'b0;
    repeat (3) @(negedge iclk);
    chk_all_zero("reset");
    irstn = 1'b1;
    #1 chk("post_release_ortr", 32'(ortr), 32'd0);
    @(negedge iclk);
    chk("first_clk_ortr", 32'(ortr), 32'd1);

    // Basic word, done 5 cycles after each request.
    run_word(32'd0, 32'd511, 0, 0, 5, 5, -1);
    chk("basic_count", 32'(oframe_count), 32'd3);
    // Wrap-around word.
    run_word(32'd1000, 32'd299, 0, 1, 0, 3, -1);
    chk("wrap_count", 32'(oframe_count), 32'd2);
    // Short reject followed back-to-back by a valid word.
    run_word(32'd10, 32'd40, 0, 0, 0, 0, -1);
    run_word(32'd100, 32'd400, 0, 2, 0, 2, -1);
    // Long backpressure with spurious completions.
    run_word(32'd5, 32'd700, 10, 10, 1, 1, -1);
    // Frame cap.
    run_word(32'd0, 32'd1023, 0, 1, 0, 2, -1);
    chk("cap_count", 32'(oframe_count), 32'd4);
    // Reset while waiting for frame 1, then a fresh word.
    run_word(32'd0, 32'd511, 0, 0, 2, 2, 1);
    run_word(32'd0, 32'd511, 0, 1, 0, 2, -1);

    // Randomized words, some of them shorter than MIN_LEN.
    for (int n = 0; n < 40; n++) begin
      s = $urandom;
      if ($urandom_range(3, 0) == 0) wl = $urandom_range(MIN_LEN - 1, 1);
      else wl = $urandom_range(BUF_DEPTH, 1);
      run_word(s, s + 32'(wl - 1), 0, 3, 0, 4, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/word_frame_sequencer.md
Name: word_frame_sequencer

Overview:
- Consumes one clipped-word descriptor (start/end sample address) per transaction from the word clipper's output stage.
- Walks the word's range in the circular audio sample buffer as overlapping analysis frames (FRAME_LEN window, HOP stride).
- Issues one frame request at a time to the downstream feature extractor and waits for its completion before advancing.
- Signals word completion, or rejection of words that are too short.

Parameters:
- BUF_DEPTH, 1024: sample buffer depth in samples. Power of two. Addresses are taken modulo BUF_DEPTH.
- FRAME_LEN, 256: frame window length in samples.
- HOP, 128: stride between frame starts. Constraint: 0 < HOP <= FRAME_LEN.
- MIN_LEN, 64: minimum word length in samples. Shorter words are rejected.
- MAX_FRAMES, 16: maximum number of frames issued per word.

Ports:
- iclk  in  1  clock
- irstn  in  1  asynchronous active-low reset
- irts  in  1  descriptor valid (from clipper orts)
- ortr  out  1  ready for descriptor (to clipper irtr)
- istart_addr  in  32  word first sample address (inclusive)
- iend_addr  in  32  word last sample address (inclusive)
- oframe_rts  out  1  frame request valid
- iframe_rtr  in  1  extractor ready for request
- oframe_addr  out  32  frame start address, modulo BUF_DEPTH, zero-extended
- oframe_len  out  16  frame length in samples
- oframe_last  out  1  frame is the final frame of the word
- iframe_done  in  1  single-cycle pulse: extractor finished current frame
- oword_done  out  1  single-cycle pulse after the last frame completes
- oerr  out  1  single-cycle pulse: descriptor rejected (too short)
- oframe_count  out  8  frames completed for the current word
- obusy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous, while irstn=0):
  - state=IDLE
  - ortr=0; ortr rises on the first clock after reset release.
  - oframe_rts, oframe_last, oword_done, oerr, obusy = 0
  - oframe_addr, oframe_len, oframe_count = 0
- Handshake rule: a transfer occurs on any edge where rts&rtr are both high. Once oframe_rts is high, it and its payload stay stable until the transfer.
- All outputs are registered. States are IDLE, ISSUE, WAIT_DONE and DONE.
- IDLE:
  - ortr=1.
  - On irts&ortr, latch both addresses and compute L = ((iend_addr - istart_addr) & (BUF_DEPTH-1)) + 1. Range 1..BUF_DEPTH; start==end gives L=1; end<start wraps.
  - Clear oframe_count and set k=0.
  - If L < MIN_LEN: pulse oerr for the next cycle, stay in IDLE, keep ortr=1.
  - Otherwise: drop ortr and go to ISSUE.
- Frame k payload:
  - addr = (start + k*HOP) mod BUF_DEPTH
  - rem = L - k*HOP
  - len = min(FRAME_LEN, rem)
  - last = (rem <= FRAME_LEN) or (k == MAX_FRAMES-1)
  - Payload is computed incrementally: addr += HOP, rem -= HOP. No multiplier.
- ISSUE: oframe_rts=1 with the payload valid in the same cycle. On iframe_rtr, deassert oframe_rts the next cycle and go to WAIT_DONE.
- WAIT_DONE:
  - On iframe_done, oframe_count += 1.
  - If last: go to DONE.
  - Else: k += 1, go to ISSUE. Next oframe_rts is asserted one cycle after iframe_done.
- DONE: pulse oword_done for one cycle, go to IDLE. ortr=1 in the following cycle.
- Request-to-request latency: minimum 1 cycle from iframe_done to the next oframe_rts.
- Accept-to-request latency: first oframe_rts is asserted 1 cycle after descriptor acceptance.
- Ignored inputs:
  - iframe_done outside WAIT_DONE.
  - irts outside IDLE (ortr is low, so no transfer occurs).
- Simultaneous iframe_rtr and iframe_done in ISSUE: the done is ignored. A done is valid only in WAIT_DONE.
- oframe_count holds its final value after DONE until the next descriptor is accepted.
- Asynchronous reset mid-word aborts immediately: no oword_done, state IDLE, all outputs return to reset values.

Test Plan:
- Defaults used below: BUF_DEPTH=1024, FRAME_LEN=256, HOP=128, MIN_LEN=64.
- Basic word: start=0, end=511 (L=512), extractor always ready, done 5 cycles after each request -> frames (0,256,last=0), (128,256,0), (256,256,1); oword_done pulses once; oframe_count=3; ortr high again.
- Wrap-around: start=1000, end=299 (L=324) -> frames (1000,256,0), then (104,196,1); oframe_count=2.
- Short reject: start=10, end=40 (L=31) -> oerr pulses one cycle; oframe_rts never asserts; ortr stays/returns high next cycle; a back-to-back valid descriptor is then accepted.
- Backpressure: hold iframe_rtr=0 for 10 cycles during ISSUE -> oframe_rts, addr, len and last stay stable; ortr=0; spurious iframe_done during ISSUE does not increment oframe_count.
- Frame cap: MAX_FRAMES=4, start=0, end=1023 -> exactly 4 frames at 0, 128, 256, 384; 4th has last=1 and len=256; oframe_count=4.
- Reset mid-word: assert irstn=0 in WAIT_DONE of frame 1 -> all outputs 0 asynchronously; no oword_done; after release ortr=1 at cycle 1 and a new word sequences from k=0.
